// File: rtl/bitty_fetch_seq.sv
// rtl/bitty_fetch_seq.sv - instruction fetch/sequencer for the bitty core
// Loadable instruction memory and PC; resolves branches locally and issues the rest via run_core/done.
module bitty_fetch_seq #(
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter bit WRAP    = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_run,
  input  logic               i_done,
  input  logic [DATA_W-1:0]  i_last_alu_result,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [INSTR_W-1:0] i_wr_data,
  output logic               o_run_core,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_busy,
  output logic               o_halted
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_BRANCH, S_HALT
  } state_t;

  state_t             r_state;
  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [INSTR_W-1:0] r_rdata;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_run_core;
  logic               r_busy;
  logic               r_halted;

  logic               w_wr_ok;
  logic               w_taken;
  logic               w_exit;
  logic               w_jump;
  logic               w_stop;
  logic [ADDR_W-1:0]  w_target;
  logic [ADDR_W-1:0]  w_pc_inc;

  assign w_wr_ok  = i_wr_en && !i_reset && (r_state == S_IDLE || r_state == S_HALT);
  assign w_target = r_rdata[4+ADDR_W-1:4];
  assign w_pc_inc = r_pc + ADDR_W'(1);

  // Writes only land in IDLE/HALT, so r_rdata keeps mem[pc] stable through DECODE and BRANCH.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_mem[i_wr_addr] <= i_wr_data;
    r_rdata <= r_mem[r_pc];
  end

  always_comb begin
    w_taken = 1'b0;
    case (r_rdata[3:2])
      2'b00:   w_taken = (i_last_alu_result == DATA_W'(0));
      2'b01:   w_taken = (i_last_alu_result == DATA_W'(1));
      2'b10:   w_taken = (i_last_alu_result == DATA_W'(2));
      default: w_taken = 1'b1;
    endcase
  end

  assign w_exit = (r_state == S_WAIT && i_done) || (r_state == S_BRANCH);
  assign w_jump = (r_state == S_BRANCH) && w_taken;
  assign w_stop = !w_jump && !WRAP && (r_pc == ADDR_W'(DEPTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_run_core <= 1'b0;
      r_instr    <= '0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_run_core <= 1'b0;
      case (r_state)
        S_IDLE: if (i_run) begin
          r_state <= S_FETCH;
          r_busy  <= 1'b1;
        end
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          if (r_rdata == '1) begin
            r_state  <= S_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else if (r_rdata[1:0] == 2'b10) begin
            r_state <= S_BRANCH;
          end else begin
            r_state    <= S_ISSUE;
            r_run_core <= 1'b1;
            r_instr    <= r_rdata;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT, S_BRANCH: if (w_exit) begin
          if (w_stop) begin
            r_state  <= S_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_pc    <= w_jump ? w_target : w_pc_inc;
            r_state <= i_run ? S_FETCH : S_IDLE;
            r_busy  <= i_run;
          end
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_run_core = r_run_core;
  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_busy     = r_busy;
  assign o_halted   = r_halted;
endmodule

// File: tb/tb_bitty_fetch_seq.sv
// tb/tb_bitty_fetch_seq.sv - randomized self-checking bench for bitty_fetch_seq
// Program-level interpreter predicts the issued instruction stream, final pc and halt.
module tb_bitty_fetch_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run, done, wr_en;
  logic [15:0] res, wr_data, instr;
  logic [7:0]  wr_addr, pc;
  logic        run_core, busy, halted;

  logic        s_reset, s_run, s_done, s_wr_en;
  logic [15:0] s_res, s_wr_data, s_instr;
  logic [1:0]  s_wr_addr, s_pc;
  logic        s_run_core, s_busy, s_halted;

  bitty_fetch_seq #(.INSTR_W(16), .DATA_W(16), .DEPTH(256), .ADDR_W(8), .WRAP(1'b1)) u_dut (
    .i_clk(clk), .i_reset(reset), .i_run(run), .i_done(done), .i_last_alu_result(res),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_run_core(run_core), .o_instr(instr), .o_pc(pc), .o_busy(busy), .o_halted(halted));

  bitty_fetch_seq #(.INSTR_W(16), .DATA_W(16), .DEPTH(4), .ADDR_W(2), .WRAP(1'b0)) u_small (
    .i_clk(clk), .i_reset(s_reset), .i_run(s_run), .i_done(s_done), .i_last_alu_result(s_res),
    .i_wr_en(s_wr_en), .i_wr_addr(s_wr_addr), .i_wr_data(s_wr_data),
    .o_run_core(s_run_core), .o_instr(s_instr), .o_pc(s_pc), .o_busy(s_busy), .o_halted(s_halted));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] prog [256];
  logic [15:0] res_tab [64];
  logic [15:0] exp_q[$];
  int          exp_pc[$];
  int          m_pc;
  logic [15:0] cap_q[$];
  int          cap_pc[$];
  int          cap_cyc[$];
  int          cyc = 0;
  bit          auto_ack = 1'b0;
  bit          rand_ack = 1'b0;
  bit          rand_drop = 1'b0;
  int          ack_cnt = 0;
  int          rerun = 0;
  int          n_done = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Core stand-in: records each issue, acks it after a delay, and may pause sequencing.
  initial forever begin
    @(negedge clk);
    if (auto_ack) done = 1'b0;
    if (rerun > 0) begin
      rerun--;
      if (rerun == 0) run = 1'b1;
    end
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0 && auto_ack) begin
        done = 1'b1;
        n_done++;
        res = res_tab[n_done % 64];
        if (rand_drop && $urandom_range(0, 3) == 0) begin
          run   = 1'b0;
          rerun = int'($urandom_range(1, 4));
        end
      end
    end
    if (run_core) begin
      cap_q.push_back(instr);
      cap_pc.push_back(int'(pc));
      cap_cyc.push_back(cyc);
      ack_cnt = rand_ack ? int'($urandom_range(1, 4)) : 2;
    end
  end

  // Interpreter: walk the program, branch on the latest result, retire issues in order.
  task automatic model_run();
    int mpc = 0;
    int k = 0;
    logic [15:0] r = res_tab[0];
    exp_q.delete();
    exp_pc.delete();
    for (int step = 0; step < 600; step++) begin
      logic [15:0] w = prog[mpc];
      if (w == 16'hFFFF) break;
      if (w[1:0] == 2'b10) begin
        if (w[3:2] == 2'b11 || r == {14'd0, w[3:2]}) mpc = int'(w[11:4]);
        else mpc = (mpc + 1) % 256;
      end else begin
        exp_q.push_back(w);
        exp_pc.push_back(mpc);
        k++;
        r = res_tab[k % 64];
        mpc = (mpc + 1) % 256;
      end
    end
    m_pc = mpc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; run = 1'b0; done = 1'b0; wr_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_prog();
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 8'(a); wr_data = prog[a];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic fill_halt();
    for (int a = 0; a < 256; a++) prog[a] = 16'hFFFF;
  endtask

  task automatic wait_issue(input string tag);
    int t = 0;
    while (!run_core && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk(tag, run_core, 1);
  endtask

  task automatic run_prog(input string tag, input int exp_lat, input bit rnd);
    int lat = 0;
    int t = 0;
    int n;
    do_reset();
    load_prog();
    auto_ack = 1'b1; rand_ack = rnd; rand_drop = rnd;
    ack_cnt = 0; rerun = 0; n_done = 0; res = res_tab[0];
    cap_q.delete(); cap_pc.delete(); cap_cyc.delete();
    model_run();
    @(negedge clk);
    run = 1'b1;
    if (exp_lat > 0) begin
      do begin
        @(negedge clk);
        lat++;
      end while (!run_core && lat < 50);
      chk({tag, "_lat"}, lat, exp_lat);
    end
    while (!halted && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_halted"}, halted, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_n_issue"}, cap_q.size(), exp_q.size());
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_instr"}, cap_q[i], exp_q[i]);
      chk({tag, "_ipc"}, cap_pc[i], exp_pc[i]);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; done = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; res = '0;
    s_reset = 1'b1; s_run = 1'b0; s_done = 1'b0; s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
    s_res = '0;
    repeat (2) @(negedge clk);
    chk("rst_run_core", run_core, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);

    for (int k = 0; k < 64; k++) res_tab[k] = 16'd0;
    fill_halt();
    prog[0] = 16'h1003; prog[1] = 16'h2003; prog[2] = 16'h1003;
    run_prog("seq3", 3, 1'b0);
    chk("seq3_gap", (cap_cyc.size() >= 2) ? cap_cyc[1] - cap_cyc[0] : 0, 5);

    fill_halt();
    prog[0] = 16'h0052; prog[1] = 16'h1003; prog[5] = 16'h2003;
    run_prog("br_taken", 6, 1'b0);
    for (int k = 0; k < 64; k++) res_tab[k] = 16'd1;
    run_prog("br_not", 6, 1'b0);

    fill_halt();
    prog[0] = 16'h1003; prog[1] = 16'h0FE2; prog[254] = 16'h2003; prog[255] = 16'h3003;
    res_tab[0] = 16'd0; res_tab[1] = 16'd0;
    run_prog("wrap", 3, 1'b0);

    auto_ack = 1'b0;
    fill_halt();
    prog[0] = 16'h1003; prog[1] = 16'h2003;
    do_reset();
    load_prog();
    cap_q.delete(); cap_pc.delete(); cap_cyc.delete();
    @(negedge clk); run = 1'b1;
    wait_issue("p_iss0");
    @(negedge clk); wr_en = 1'b1; wr_addr = 8'd0; wr_data = 16'h5551;
    @(negedge clk); wr_en = 1'b0; run = 1'b0; done = 1'b1;
    @(negedge clk); done = 1'b0;
    chk("pause_busy", busy, 0);
    chk("pause_pc", pc, 1);
    repeat (4) @(negedge clk);
    chk("pause_nofetch", cap_q.size(), 1);
    @(negedge clk); run = 1'b1;
    wait_issue("p_iss1");
    chk("resume_pc", pc, 1);
    chk("resume_instr", instr, 16'h2003);
    @(negedge clk); reset = 1'b1; done = 1'b1; run = 1'b0;
    @(negedge clk); reset = 1'b0; done = 1'b0;
    chk("wrst_run_core", run_core, 0);
    chk("wrst_instr", instr, 0);
    chk("wrst_pc", pc, 0);
    chk("wrst_busy", busy, 0);
    chk("wrst_halted", halted, 0);
    repeat (3) @(negedge clk);
    chk("wrst_pc_hold", pc, 0);
    @(negedge clk); run = 1'b1;
    wait_issue("w_iss0");
    chk("wait_wr_ignored", instr, 16'h1003);
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
    wait_issue("w_iss1");
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
    for (int t = 0; t < 20 && !halted; t++) @(negedge clk);
    chk("w_halted", halted, 1);
    chk("w_halt_pc", pc, 2);
    @(negedge clk); wr_en = 1'b1; wr_addr = 8'd0; wr_data = 16'h5551;
    @(negedge clk); wr_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("halt_sticky", halted, 1);
    chk("halt_run_ignored", busy, 0);
    do_reset();
    @(negedge clk); run = 1'b1;
    wait_issue("h_iss0");
    chk("halt_wr_taken", instr, 16'h5551);

    @(negedge clk); s_reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      s_wr_en = 1'b1; s_wr_addr = 2'(a); s_wr_data = 16'h3001 | 16'(a << 4);
    end
    @(negedge clk); s_wr_en = 1'b0; s_run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int t = 0;
      while (!s_run_core && t < 40) begin
        @(negedge clk);
        t++;
      end
      chk("s_issue", s_run_core, 1);
      chk("s_instr", s_instr, 16'h3001 | 16'(k << 4));
      chk("s_pc", s_pc, k);
      @(negedge clk); s_done = 1'b1;
      @(negedge clk); s_done = 1'b0;
    end
    @(negedge clk);
    chk("s_halted", s_halted, 1);
    chk("s_halt_pc", s_pc, 3);
    chk("s_busy", s_busy, 0);

    for (int it = 0; it < 6; it++) begin
      fill_halt();
      for (int a = 0; a < 15; a++) begin
        logic [15:0] w = 16'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          w[1:0]  = 2'b10;
          w[11:4] = 8'($urandom_range(a + 1, 15));
        end else begin
          if (w[1:0] == 2'b10) w[1:0] = 2'b00;
          if (w == 16'hFFFF) w = 16'h0001;
        end
        prog[a] = w;
      end
      for (int k = 0; k < 64; k++) res_tab[k] = 16'($urandom_range(0, 3));
      run_prog("rnd", 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
